// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART configuration receiver.
//   rx_state_t  - byte-level receive FSM states
//   pkt_state_t - packet parser states (addr, data, chk)
//   pkt_chk()   - packet checksum (addr XOR data), computed at CHK_W bits
//                 and truncated by the caller to its data width
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  typedef enum logic [1:0] {
    P_ADDR,
    P_DATA,
    P_CHK
  } pkt_state_t;

  localparam int unsigned CHK_W = 16;

  function automatic logic [CHK_W-1:0] pkt_chk(input logic [CHK_W-1:0] addr,
                                               input logic [CHK_W-1:0] data);
    return addr ^ data;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: single-byte UART receiver (start, DATA_BITS data LSB-first, stop).
// Ports:
//   clk        - system clock
//   rst_n      - synchronous active-low reset
//   uart_data  - asynchronous serial line, idles high
//   byte_valid - one-cycle pulse, byte_data holds the received byte
//   byte_data  - last received byte
//   frame_err  - one-cycle pulse when the stop bit is sampled low
//   active     - byte FSM is not idle
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 52,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_data,
  output logic                 byte_valid,
  output logic [DATA_BITS-1:0] byte_data,
  output logic                 frame_err,
  output logic                 active
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF_LD  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  logic                 sync1, sync2, line_d;
  logic [2:0]           primed;
  logic                 fall;
  rx_state_t            state;
  logic [CW-1:0]        bit_cnt;
  logic [IW-1:0]        data_idx;
  logic [DATA_BITS-1:0] shreg;

  // primed marks which pipeline stages hold real line samples rather than
  // reset values, so a line held low through reset cannot fake a falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      line_d <= 1'b1;
      primed <= '0;
    end else begin
      sync1  <= uart_data;
      sync2  <= sync1;
      line_d <= sync2;
      primed <= {primed[1:0], 1'b1};
    end
  end

  assign fall   = primed[2] & line_d & ~sync2;
  assign active = (state != RX_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RX_IDLE;
      bit_cnt    <= '0;
      data_idx   <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        RX_IDLE: begin
          if (fall) begin
            state   <= RX_START;
            bit_cnt <= HALF_LD;
          end
        end
        RX_START: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - CW'(1);
          end else if (sync2) begin
            state <= RX_IDLE;
          end else begin
            state    <= RX_DATA;
            bit_cnt  <= FULL_LD;
            data_idx <= '0;
          end
        end
        RX_DATA: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - CW'(1);
          end else begin
            shreg   <= {sync2, shreg[DATA_BITS-1:1]};
            bit_cnt <= FULL_LD;
            if (data_idx == LAST_IDX) begin
              state <= RX_STOP;
            end else begin
              data_idx <= data_idx + IW'(1);
            end
          end
        end
        RX_STOP: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - CW'(1);
          end else if (sync2) begin
            byte_valid <= 1'b1;
            byte_data  <= shreg;
            state      <= RX_IDLE;
          end else begin
            frame_err <= 1'b1;
            state     <= RX_BREAK;
          end
        end
        RX_BREAK: begin
          if (sync2) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cfg_rx.sv
// uart_cfg_rx: addressed UART configuration loader. Packets are three bytes
// (addr, data, chk = addr ^ data); a valid packet writes par[addr].
// Ports:
//   clk       - system clock
//   rst_n     - synchronous active-low reset
//   uart_data - asynchronous serial line, idles high
//   par       - PAR_NUM config registers of DATA_BITS each
//   par_upd   - one-cycle pulse when a par entry is written
//   par_idx   - index of the last written entry
//   frame_err - one-cycle pulse on a low stop bit
//   pkt_err   - one-cycle pulse on bad checksum, bad address or timeout
//   busy      - byte receiver active or packet in progress
module uart_cfg_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 52,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PAR_NUM      = 5,
  parameter int unsigned PAR_RST      = 0,
  parameter int unsigned TIMEOUT_BITS = 20,
  localparam int unsigned IDX_W = (PAR_NUM > 1) ? $clog2(PAR_NUM) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              uart_data,
  output logic [PAR_NUM-1:0][DATA_BITS-1:0] par,
  output logic                              par_upd,
  output logic [IDX_W-1:0]                  par_idx,
  output logic                              frame_err,
  output logic                              pkt_err,
  output logic                              busy
);

  localparam int unsigned TMO = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned GW  = $clog2(TMO + 1);
  localparam logic [GW-1:0] TMO_CNT = GW'(TMO);

  logic                 byte_valid;
  logic [DATA_BITS-1:0] byte_data;
  logic                 rx_active;
  pkt_state_t           pstate;
  logic [DATA_BITS-1:0] addr_q, data_q;
  logic [GW-1:0]        gap_cnt;
  logic [CHK_W-1:0]     chk_exp;
  logic                 chk_ok, addr_ok;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_BITS   (DATA_BITS)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_data (uart_data),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err),
    .active    (rx_active)
  );

  assign chk_exp = pkt_chk(CHK_W'(addr_q), CHK_W'(data_q));
  assign chk_ok  = (byte_data == chk_exp[DATA_BITS-1:0]);
  assign addr_ok = (32'(addr_q) < PAR_NUM);
  assign busy    = rx_active | (pstate != P_ADDR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pstate  <= P_ADDR;
      addr_q  <= '0;
      data_q  <= '0;
      gap_cnt <= '0;
      par     <= {PAR_NUM{DATA_BITS'(PAR_RST)}};
      par_upd <= 1'b0;
      par_idx <= '0;
      pkt_err <= 1'b0;
    end else begin
      par_upd <= 1'b0;
      pkt_err <= 1'b0;
      unique case (pstate)
        P_ADDR: begin
          gap_cnt <= '0;
          if (byte_valid) begin
            addr_q <= byte_data;
            pstate <= P_DATA;
          end
        end
        P_DATA, P_CHK: begin
          // byte_valid outranks the timeout terminal count in the same cycle.
          if (byte_valid) begin
            gap_cnt <= '0;
            if (pstate == P_DATA) begin
              data_q <= byte_data;
              pstate <= P_CHK;
            end else begin
              pstate <= P_ADDR;
              if (chk_ok && addr_ok) begin
                par[addr_q[IDX_W-1:0]] <= data_q;
                par_upd                <= 1'b1;
                par_idx                <= addr_q[IDX_W-1:0];
              end else begin
                pkt_err <= 1'b1;
              end
            end
          end else if (frame_err) begin
            pstate  <= P_ADDR;
            gap_cnt <= '0;
          end else if (gap_cnt == TMO_CNT) begin
            pkt_err <= 1'b1;
            pstate  <= P_ADDR;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: pstate <= P_ADDR;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cfg_rx.sv
// tb_uart_cfg_rx: randomized self-checking bench for uart_cfg_rx. Two
// instances (52 clk/bit 8-bit x5, and 16 clk/bit 7-bit x3) are exercised in
// turn; sel routes the stimulus line and the observed outputs.
module tb_uart_cfg_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, line, sel;
  logic uart0, uart1;
  assign uart0 = sel ? 1'b1 : line;
  assign uart1 = sel ? line : 1'b1;

  logic [4:0][7:0] par0;
  logic [2:0][6:0] par1;
  logic [2:0]      par_idx0;
  logic [1:0]      par_idx1;
  logic par_upd0, frame_err0, pkt_err0, busy0;
  logic par_upd1, frame_err1, pkt_err1, busy1;

  uart_cfg_rx #(
    .CLKS_PER_BIT(52), .DATA_BITS(8), .PAR_NUM(5), .PAR_RST(0), .TIMEOUT_BITS(20)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .uart_data(uart0), .par(par0), .par_upd(par_upd0),
    .par_idx(par_idx0), .frame_err(frame_err0), .pkt_err(pkt_err0), .busy(busy0)
  );

  uart_cfg_rx #(
    .CLKS_PER_BIT(16), .DATA_BITS(7), .PAR_NUM(3), .PAR_RST(0), .TIMEOUT_BITS(20)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .uart_data(uart1), .par(par1), .par_upd(par_upd1),
    .par_idx(par_idx1), .frame_err(frame_err1), .pkt_err(pkt_err1), .busy(busy1)
  );

  // Unified view of the selected instance
  logic [7:0] pv [5];
  logic v_upd, v_fe, v_pkt, v_busy;
  int   v_idx;
  always_comb begin
    pv[0]  = sel ? {1'b0, par1[0]} : par0[0];
    pv[1]  = sel ? {1'b0, par1[1]} : par0[1];
    pv[2]  = sel ? {1'b0, par1[2]} : par0[2];
    pv[3]  = sel ? 8'h00 : par0[3];
    pv[4]  = sel ? 8'h00 : par0[4];
    v_upd  = sel ? par_upd1   : par_upd0;
    v_fe   = sel ? frame_err1 : frame_err0;
    v_pkt  = sel ? pkt_err1   : pkt_err0;
    v_busy = sel ? busy1      : busy0;
    v_idx  = sel ? int'(par_idx1) : int'(par_idx0);
  end

  // Pulse monitor: counts high cycles of each strobe
  int n_upd = 0, n_pkt = 0, n_fe = 0, last_idx = -1;
  always @(negedge clk) begin
    if (v_upd) begin
      n_upd    = n_upd + 1;
      last_idx = v_idx;
    end
    if (v_pkt) n_pkt = n_pkt + 1;
    if (v_fe)  n_fe  = n_fe + 1;
  end

  int n_chk = 0, n_err = 0;
  int cpb, db, pn, tmo, mask;
  int exp_par [5];

  task automatic check(input string tag, input int got, input int exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s (cfg %0d): got %0d (0x%0h) expected %0d (0x%0h)",
               tag, sel, got, got, exp, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the line at the stop level so a low stop bit becomes a break
  task automatic send_frame(input int b, input int stop);
    line = 1'b0;
    idle(cpb);
    for (int i = 0; i < db; i++) begin
      line = b[i];
      idle(cpb);
    end
    line = stop[0];
    idle(cpb);
  endtask

  task automatic send_byte(input int b);
    send_frame(b, 1);
  endtask

  task automatic check_par();
    for (int i = 0; i < pn; i++)
      check($sformatf("par[%0d]", i), int'(pv[i]), exp_par[i]);
  endtask

  task automatic expect_pkt(input int a, input int d, input int c, input int gap);
    int u0, p0, f0, ok;
    u0 = n_upd; p0 = n_pkt; f0 = n_fe;
    send_byte(a); idle(gap);
    send_byte(d); idle(gap);
    send_byte(c); idle(8);
    ok = ((c == (a ^ d)) && (a < pn)) ? 1 : 0;
    if (ok == 1) exp_par[a] = d;
    check("par_upd count", n_upd - u0, ok);
    check("pkt_err count", n_pkt - p0, 1 - ok);
    check("frame_err count", n_fe - f0, 0);
    if (ok == 1) check("par_idx", last_idx, a);
    check("busy after pkt", int'(v_busy), 0);
    check_par();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(4);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) exp_par[i] = 0;
    idle(4);
  endtask

  task automatic run_cfg(input logic s);
    int u0, p0, f0, a, d, c, cyc, seen;
    sel  = s;
    line = 1'b1;
    if (s == 1'b0) begin cpb = 52; db = 8; pn = 5; end
    else           begin cpb = 16; db = 7; pn = 3; end
    tmo  = 20 * cpb;
    mask = (1 << db) - 1;

    // Reset state, idle line
    u0 = n_upd; p0 = n_pkt; f0 = n_fe;
    do_reset();
    idle(20);
    check("reset upd", n_upd - u0, 0);
    check("reset pkt_err", n_pkt - p0, 0);
    check("reset frame_err", n_fe - f0, 0);
    check("reset busy", int'(v_busy), 0);
    check_par();

    // Directed packets: good, bad checksum, bad address
    expect_pkt(8'h02, 8'h7F, 8'h7D, 0);
    expect_pkt(8'h01, 8'h10, 8'h00, 0);
    expect_pkt(8'h07, 8'h33, 8'h34, 0);

    // Short glitch must not start a frame
    u0 = n_upd; f0 = n_fe;
    line = 1'b0;
    idle((cpb == 52) ? 10 : 3);
    line = 1'b1;
    idle(3 * cpb);
    check("glitch frame_err", n_fe - f0, 0);
    check("glitch upd", n_upd - u0, 0);
    check("glitch busy", int'(v_busy), 0);
    expect_pkt(8'h01, 8'h55, 8'h54, 0);

    // Low stop bit mid-packet: one frame_err, parser restarts
    p0 = n_pkt; f0 = n_fe; u0 = n_upd;
    send_byte(8'h01);
    send_frame(8'h22, 0);
    idle(3 * cpb);
    line = 1'b1;
    idle(cpb);
    check("break frame_err", n_fe - f0, 1);
    check("break pkt_err", n_pkt - p0, 0);
    check("break upd", n_upd - u0, 0);
    check("break busy", int'(v_busy), 0);
    expect_pkt(8'h00, 8'h3C, 8'h3C, 0);

    // Inter-byte timeout
    p0 = n_pkt; u0 = n_upd;
    send_byte(8'h03);
    cyc = 0; seen = 0;
    while (seen == 0 && cyc <= tmo + 2 * cpb) begin
      idle(1);
      cyc = cyc + 1;
      if (n_pkt != p0) seen = 1;
    end
    check("timeout seen", seen, 1);
    check("timeout window", (cyc >= tmo - 2 * cpb && cyc <= tmo) ? 1 : 0, 1);
    idle(4);
    check("timeout pkt_err count", n_pkt - p0, 1);
    check("timeout upd", n_upd - u0, 0);
    check("timeout busy", int'(v_busy), 0);
    a = (3 < pn) ? 3 : pn - 1;
    d = 8'hAA & mask;
    expect_pkt(a, d, a ^ d, 0);
    // Gaps just inside the timeout still accepted
    d = 8'h5B & mask;
    expect_pkt(a, d, a ^ d, tmo - 12 * cpb);

    // Reset in the middle of a packet's data byte, line low across release
    send_byte(8'h01);
    line = 1'b0;
    idle(4 * cpb);
    u0 = n_upd; p0 = n_pkt; f0 = n_fe;
    do_reset();
    idle(2 * cpb);
    line = 1'b1;
    idle(3 * cpb);
    check("midrst upd", n_upd - u0, 0);
    check("midrst pkt_err", n_pkt - p0, 0);
    check("midrst frame_err", n_fe - f0, 0);
    check("midrst busy", int'(v_busy), 0);
    check_par();

    // Back-to-back packets, no idle at all
    u0 = n_upd; p0 = n_pkt;
    send_byte(1); send_byte(8'h21 & mask); send_byte(1 ^ (8'h21 & mask));
    send_byte(0); send_byte(8'h6E & mask); send_byte(8'h6E & mask);
    idle(8);
    exp_par[1] = 8'h21 & mask;
    exp_par[0] = 8'h6E & mask;
    check("b2b upd count", n_upd - u0, 2);
    check("b2b pkt_err", n_pkt - p0, 0);
    check("b2b par_idx", last_idx, 0);
    check_par();

    // Randomized packets against the reference model
    for (int k = 0; k < ((s == 1'b0) ? 10 : 16); k++) begin
      if ($urandom_range(0, 3) == 0) a = int'($urandom_range(0, mask));
      else                           a = int'($urandom_range(0, pn - 1));
      d = int'($urandom) & mask;
      if ($urandom_range(0, 3) == 0) c = int'($urandom) & mask;
      else                           c = a ^ d;
      expect_pkt(a, d, c, int'($urandom_range(0, 2 * cpb)));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    line  = 1'b1;
    sel   = 1'b0;
    idle(2);
    run_cfg(1'b0);
    run_cfg(1'b1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/uart_cfg_rx.md
Name: uart_cfg_rx

Overview:
- Parametrised UART configuration receiver; next generation of the serial config loader feeding the DRSSTC controller registers (ref_gen, phase_shift, ocd_lvl, inter_freq, inter_duty, plus future parameters).
- Receives 8N1-style frames of DATA_BITS data bits with mid-bit sampling, glitch rejection and framing-error detection.
- Replaces fixed round-robin loading with addressed 3-byte packets: addr, data, chk. Adds checksum, inter-byte timeout, reset and update strobes.

Parameters:
- CLKS_PER_BIT, 52, clk cycles per UART bit; must be >= 4.
- DATA_BITS, 8, data bits per frame and width of each config parameter.
- PAR_NUM, 5, number of config registers; must be <= 2**DATA_BITS.
- PAR_RST, 0, reset value of every config register.
- TIMEOUT_BITS, 20, maximum gap between bytes of one packet, in bit times.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active-low
- uart_data  input  1  asynchronous serial line; idles high
- par  output  [PAR_NUM][DATA_BITS]  config register array
- par_upd  output  1  one-cycle pulse when a par entry is written
- par_idx  output  $clog2(PAR_NUM) (min 1)  index of the last written entry
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low
- pkt_err  output  1  one-cycle pulse on checksum mismatch, address >= PAR_NUM, or timeout
- busy  output  1  high while the byte FSM is not RX_IDLE or the parser is not P_ADDR

Behaviour:
- Reset: clk is the only clock. rst_n is sampled on the rising edge of clk and is active-low.
  - While rst_n is low, all par entries are loaded with PAR_RST.
  - par_idx=0. par_upd, frame_err, pkt_err and busy are 0.
  - Synchroniser flops are set to 1. FSMs go to RX_IDLE and P_ADDR. All counters are cleared.
  - A reset asserted mid-frame or mid-packet aborts it silently; no error pulse is produced.
- Input path: 2-FF synchroniser, then a one-cycle delayed copy for falling-edge detection. This gives 2 cycles of latency into the FSM.
  - Because start detection is edge-based, a line held low through reset never starts a frame until a high level has been seen.
- Byte FSM (sub-module):
  - RX_IDLE: on a falling edge, go to RX_START and load bit_cnt = CLKS_PER_BIT/2 - 1.
  - RX_START: count down. At 0, sample the line.
    - If high, treat it as a glitch and return to RX_IDLE with no error.
    - If low, go to RX_DATA with bit_cnt = CLKS_PER_BIT - 1 and data_idx = 0.
  - RX_DATA: count down. At 0, shift the sample in LSB-first and reload the counter. After DATA_BITS samples, go to RX_STOP.
  - RX_STOP: count down. At 0, sample the line.
    - If 1, pulse byte_valid for one cycle with the byte, and go to RX_IDLE immediately, so back-to-back frames are accepted.
    - If 0, pulse frame_err, discard the byte, and go to RX_BREAK.
  - RX_BREAK: wait for the line to be high, then go to RX_IDLE. A break (line held low) yields exactly one frame_err.
- Packet parser:
  - P_ADDR: on byte_valid, latch addr and go to P_DATA.
  - P_DATA: on byte_valid, latch data and go to P_CHK.
  - P_CHK: on byte_valid, compare the byte with addr ^ data, then go to P_ADDR in all cases.
    - Match and addr < PAR_NUM: write par[addr] <= data. On the next cycle after byte_valid, par_upd=1 and par_idx=addr.
    - Otherwise: pulse pkt_err on that same next cycle; par is unchanged.
  - Timeout:
    - In P_DATA and P_CHK, gap_cnt increments every cycle and clears on byte_valid.
    - At TIMEOUT_BITS*CLKS_PER_BIT, pulse pkt_err and go to P_ADDR.
    - gap_cnt width is $clog2(TIMEOUT_BITS*CLKS_PER_BIT+1).
  - frame_err while the parser is in P_DATA or P_CHK also returns it to P_ADDR; pkt_err is not pulsed in that case.
  - Simultaneous events: byte_valid and the timeout terminal count in the same cycle → byte_valid wins and gap_cnt clears.
- Outputs are registered. par holds its value between writes. Writing the same value still pulses par_upd.
- Arithmetic: all counters are unsigned. Count-downs stop at 0 and are reloaded by the state logic; there is no wrap.

Decomposition:
- Shared package uart_pkg holds:
  - typedef rx_state_t {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK}
  - typedef pkt_state_t {P_ADDR, P_DATA, P_CHK}
  - the checksum function
- Sub-module uart_rx_byte contains the synchroniser, edge detector and byte FSM. Its outputs are byte_valid, byte_data and frame_err.
- Top level uart_cfg_rx contains the parser, timeout counter and the par register array.

Test Plan:
- Reset release, idle line → par all 0, no pulses, busy=0. Send 0x02,0x7F,0x7D at 52 clk/bit → par[2]=0x7F; par_upd for exactly 1 cycle with par_idx=2; other entries stay 0.
- Packet 0x01,0x10,0x00 (bad chk) → pkt_err pulse, par[1] unchanged. Packet 0x07,0x33,0x34 (addr >= 5) → pkt_err pulse, no write.
- 10-clk low glitch on the idle line → no byte_valid, no frame_err. Then send a valid packet → accepted.
- Frame whose stop bit is forced low → one frame_err pulse; FSM waits for the line to go high; the parser restarts at P_ADDR. A following full packet writes correctly.
- Send 0x03, then 1041 idle cycles (> 20*52) → pkt_err pulse at gap 1040, parser back to P_ADDR. Then 0x03,0xAA,0xA9 → par[3]=0xAA.
- rst_n low during the data byte of a packet → no pulses, par all 0 after reset. Back-to-back packets with no idle gap → both written. Repeat with DATA_BITS=7, PAR_NUM=3, CLKS_PER_BIT=16.
